// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: buffers host commands and issues them one at a time to the 8x8 LCD controller.
// Define LCD_SEQ_POS_TRACK_EN to suppress shift commands that would leave the 1..7 operation window.
module lcd_cmd_sequencer #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic       seq_idle,
    output logic       seq_done,
    output logic       err_timeout,
    output logic [7:0] issued_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [7:0]       TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    // IDLE: wait/pop | ISSUE: strobe | WAIT_ACK: await busy | WAIT_DONE: await release | FINISH: terminal
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t state, state_next;

    logic [3:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       ack_timer;
    logic [3:0]       head;
    logic             push, pop, accept, timeout_hit, fifo_flush, shift_blocked;

    assign head          = fifo_mem[rd_ptr];
    assign host_ready    = (count < DEPTH_C) && (state != FINISH);
    assign push          = host_valid && host_ready;
    assign lcd_cmd_valid = (state == ISSUE);
    assign seq_idle      = (state == IDLE) && (count == '0);
    assign fifo_flush    = (state == WAIT_ACK) && (state_next == FINISH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!lcd_busy && count != '0) begin
                    pop = 1'b1;
                    if (!shift_blocked) begin
                        accept     = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A late ack in the final timer cycle takes priority over the timeout.
                if (lcd_busy) begin
                    state_next = (lcd_cmd == 4'd0) ? FINISH : WAIT_DONE;
                end else if (ack_timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_next = IDLE;
                end
            end
            FINISH: begin
                state_next = FINISH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_timer <= 8'd0;
        end else if (state == WAIT_ACK && state_next == WAIT_ACK) begin
            ack_timer <= ack_timer + 8'd1;
        end else begin
            ack_timer <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_cmd     <= 4'd0;
            issued_cnt  <= 8'd0;
            err_timeout <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            if (accept) begin
                lcd_cmd <= head;
            end
            if (state == ISSUE && issued_cnt != 8'hFF) begin
                issued_cnt <= issued_cnt + 8'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (state == FINISH && lcd_done) begin
                seq_done <= 1'b1;
            end
        end
    end

`ifdef LCD_SEQ_POS_TRACK_EN
    logic [2:0] row, col;

    always_comb begin
        shift_blocked = 1'b0;
        case (head)
            4'd1:    shift_blocked = (row == 3'd1);
            4'd2:    shift_blocked = (row == 3'd7);
            4'd3:    shift_blocked = (col == 3'd1);
            4'd4:    shift_blocked = (col == 3'd7);
            default: shift_blocked = 1'b0;
        endcase
    end

    // Position moves only for shifts that are actually sent to the controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= 3'd4;
            col <= 3'd4;
        end else if (accept) begin
            case (head)
                4'd1:    row <= row - 3'd1;
                4'd2:    row <= row + 3'd1;
                4'd3:    col <= col - 3'd1;
                4'd4:    col <= col + 3'd1;
                default: ;
            endcase
        end
    end
`else
    assign shift_blocked = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed self-checking bench for lcd_cmd_sequencer with a small LCD controller model.
module tb_lcd_cmd_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic       seq_idle;
    logic       seq_done;
    logic       err_timeout;
    logic [7:0] issued_cnt;

    logic       model_busy;
    logic       hold_busy;
    logic       model_en;
    logic       model_noack_en;
    logic [3:0] model_noack_cmd;
    int         model_hold;

    int checks;
    int errors;
    logic [3:0] issued_q[$];

`ifdef LCD_SEQ_POS_TRACK_EN
    localparam int EXP_SHIFT = 3;
`else
    localparam int EXP_SHIFT = 4;
`endif

    assign lcd_busy = model_busy | hold_busy;

    lcd_cmd_sequencer #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .lcd_cmd      (lcd_cmd),
        .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy     (lcd_busy),
        .lcd_done     (lcd_done),
        .seq_idle     (seq_idle),
        .seq_done     (seq_done),
        .err_timeout  (err_timeout),
        .issued_cnt   (issued_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (lcd_cmd_valid) issued_q.push_back(lcd_cmd);
        end
    end

    // LCD model: raise busy in the issue cycle, hold it for model_hold cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && lcd_cmd_valid && !(model_noack_en && lcd_cmd == model_noack_cmd)) begin
                model_busy = 1'b1;
                for (int k = 0; k < model_hold && model_busy; k++) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset           = 1'b1;
        host_valid      = 1'b0;
        host_cmd        = 4'd0;
        lcd_done        = 1'b0;
        hold_busy       = 1'b0;
        model_en        = 1'b0;
        model_busy      = 1'b0;
        model_noack_en  = 1'b0;
        model_noack_cmd = 4'd0;
        model_hold      = 2;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issued_q.delete();
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [3:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rst_host_ready got %b exp 1", host_ready); end
        checks++; if (lcd_cmd !== 4'd0) begin errors++; $display("FAIL rst_lcd_cmd got %0d exp 0", lcd_cmd); end
        checks++; if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", lcd_cmd_valid); end
        checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL rst_seq_idle got %b exp 1", seq_idle); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL rst_seq_done got %b exp 0", seq_done); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err_timeout got %b exp 0", err_timeout); end
        checks++; if (issued_cnt !== 8'd0) begin errors++; $display("FAIL rst_issued_cnt got %0d exp 0", issued_cnt); end
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        @(negedge clk);
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL done_outside_finish got %b exp 0", seq_done); end
    endtask

    task automatic test_basic();
        do_reset();
        model_en   = 1'b1;
        host_cmd   = 4'd3;
        host_valid = 1'b1;
        @(negedge clk);
        host_valid = 1'b0;
        checks++; if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL lat_pre_valid got %b exp 0", lcd_cmd_valid); end
        checks++; if (seq_idle !== 1'b0) begin errors++; $display("FAIL lat_pre_idle got %b exp 0", seq_idle); end
        @(negedge clk);
        checks++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'd3) begin errors++; $display("FAIL lat_issue got valid %b cmd %0d exp valid 1 cmd 3", lcd_cmd_valid, lcd_cmd); end
        push_cmd(4'd5);
        push_cmd(4'd0);
        for (int i = 0; i < 200 && issued_q.size() < 3; i++) @(negedge clk);
        checks++; if (issued_q.size() !== 3) begin errors++; $display("FAIL basic_issue_count got %0d exp 3", issued_q.size()); end
        if (issued_q.size() >= 3) begin
            checks++; if (issued_q[0] !== 4'd3) begin errors++; $display("FAIL basic_cmd0 got %0d exp 3", issued_q[0]); end
            checks++; if (issued_q[1] !== 4'd5) begin errors++; $display("FAIL basic_cmd1 got %0d exp 5", issued_q[1]); end
            checks++; if (issued_q[2] !== 4'd0) begin errors++; $display("FAIL basic_cmd2 got %0d exp 0", issued_q[2]); end
        end
        repeat (5) @(negedge clk);
        checks++; if (issued_cnt !== 8'd3) begin errors++; $display("FAIL basic_issued_cnt got %0d exp 3", issued_cnt); end
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL basic_finish_ready got %b exp 0", host_ready); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL basic_done_early got %b exp 0", seq_done); end
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL basic_seq_done got %b exp 1", seq_done); end
        repeat (3) @(negedge clk);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL basic_done_sticky got %b exp 1", seq_done); end
    endtask

    task automatic test_fifo_full();
        int accepted;
        accepted = 0;
        do_reset();
        hold_busy  = 1'b1;
        host_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            host_cmd = 4'(i + 1);
            if (host_ready) accepted++;
            @(negedge clk);
        end
        host_valid = 1'b0;
        checks++; if (accepted !== 8) begin errors++; $display("FAIL full_accepted got %0d exp 8", accepted); end
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", host_ready); end
        checks++; if (dut.count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", dut.count); end
        checks++; if (issued_q.size() !== 0) begin errors++; $display("FAIL full_busy_issue got %0d exp 0", issued_q.size()); end
        hold_busy = 1'b0;
        model_en  = 1'b1;
        for (int i = 0; i < 300 && issued_q.size() < 8; i++) @(negedge clk);
        checks++; if (issued_q.size() !== 8) begin errors++; $display("FAIL full_drain_count got %0d exp 8", issued_q.size()); end
        for (int i = 0; i < 8 && i < issued_q.size(); i++) begin
            checks++; if (issued_q[i] !== 4'(i + 1)) begin errors++; $display("FAIL full_order_%0d got %0d exp %0d", i, issued_q[i], i + 1); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        model_en        = 1'b1;
        model_noack_en  = 1'b1;
        model_noack_cmd = 4'd7;
        host_cmd   = 4'd7;
        host_valid = 1'b1;
        @(negedge clk);
        host_cmd = 4'd2;
        @(negedge clk);
        host_valid = 1'b0;
        for (int i = 0; i < 50 && !lcd_cmd_valid; i++) @(negedge clk);
        checks++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'd7) begin errors++; $display("FAIL to_issue got valid %b cmd %0d exp valid 1 cmd 7", lcd_cmd_valid, lcd_cmd); end
        repeat (16) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_not_early got %b exp 0", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err_timeout); end
        checks++; if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL to_idle_valid got %b exp 0", lcd_cmd_valid); end
        @(negedge clk);
        checks++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'd2) begin errors++; $display("FAIL to_next_issue got valid %b cmd %0d exp valid 1 cmd 2", lcd_cmd_valid, lcd_cmd); end
        repeat (6) @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
        checks++; if (issued_cnt !== 8'd2) begin errors++; $display("FAIL to_issued_cnt got %0d exp 2", issued_cnt); end
        checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL to_final_idle got %b exp 1", seq_idle); end
    endtask

    task automatic test_pos_shift();
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(4'd1);
        repeat (60) @(negedge clk);
        checks++; if (issued_q.size() !== EXP_SHIFT) begin errors++; $display("FAIL pos_row_issued got %0d exp %0d", issued_q.size(), EXP_SHIFT); end
        checks++; if (issued_cnt !== 8'(EXP_SHIFT)) begin errors++; $display("FAIL pos_row_cnt got %0d exp %0d", issued_cnt, EXP_SHIFT); end
        checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL pos_row_idle got %b exp 1", seq_idle); end
        for (int i = 0; i < 4; i++) push_cmd(4'd4);
        repeat (60) @(negedge clk);
        checks++; if (issued_cnt !== 8'(2 * EXP_SHIFT)) begin errors++; $display("FAIL pos_col_cnt got %0d exp %0d", issued_cnt, 2 * EXP_SHIFT); end
        if (issued_q.size() > EXP_SHIFT) begin
            checks++; if (issued_q[EXP_SHIFT] !== 4'd4) begin errors++; $display("FAIL pos_col_cmd got %0d exp 4", issued_q[EXP_SHIFT]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        model_en   = 1'b1;
        model_hold = 20;
        host_cmd   = 4'd6;
        host_valid = 1'b1;
        repeat (5) @(negedge clk);
        host_valid = 1'b0;
        checks++; if (dut.count !== 4'd4) begin errors++; $display("FAIL mid_count_pre got %0d exp 4", dut.count); end
        checks++; if (lcd_cmd !== 4'd6) begin errors++; $display("FAIL mid_cmd_pre got %0d exp 6", lcd_cmd); end
        #2;
        reset      = 1'b1;
        model_busy = 1'b0;
        model_hold = 2;
        #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", host_ready); end
        checks++; if (lcd_cmd !== 4'd0) begin errors++; $display("FAIL mid_lcd_cmd got %0d exp 0", lcd_cmd); end
        checks++; if (seq_idle !== 1'b1) begin errors++; $display("FAIL mid_seq_idle got %b exp 1", seq_idle); end
        checks++; if (issued_cnt !== 8'd0) begin errors++; $display("FAIL mid_issued_cnt got %0d exp 0", issued_cnt); end
        checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", dut.count); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issued_q.delete();
        repeat (20) @(negedge clk);
        checks++; if (issued_q.size() !== 0) begin errors++; $display("FAIL mid_no_issue got %0d exp 0", issued_q.size()); end
    endtask

    task automatic test_finish_flush();
        do_reset();
        model_en = 1'b1;
        push_cmd(4'd0);
        push_cmd(4'd2);
        push_cmd(4'd4);
        repeat (30) @(negedge clk);
        checks++; if (issued_q.size() !== 1) begin errors++; $display("FAIL fin_issued got %0d exp 1", issued_q.size()); end
        if (issued_q.size() >= 1) begin
            checks++; if (issued_q[0] !== 4'd0) begin errors++; $display("FAIL fin_cmd got %0d exp 0", issued_q[0]); end
        end
        checks++; if (issued_cnt !== 8'd1) begin errors++; $display("FAIL fin_issued_cnt got %0d exp 1", issued_cnt); end
        checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL fin_count got %0d exp 0", dut.count); end
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL fin_ready got %b exp 0", host_ready); end
        push_cmd(4'd5);
        @(negedge clk);
        checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL fin_push_refused got %0d exp 0", dut.count); end
        checks++; if (seq_idle !== 1'b0) begin errors++; $display("FAIL fin_not_idle got %b exp 0", seq_idle); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_fifo_full();
        test_timeout();
        test_pos_shift();
        test_reset_mid();
        test_finish_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
